key_bounce_gen: RTL and testbench
=================================

KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Interface
REQ-001 Parameter BOUNCE_LEN, default 250000, SHALL set the bounce window length in clk cycles; legal range is 1 to 2^20-1.
REQ-002 Parameter SETTLE_LEN, default 50000, SHALL set how many cycles the final stable level is held before completion; legal range is 1 to 2^20-1.
REQ-003 Parameter GLITCH_W, default 12, SHALL set the bit width of the random glitch length; legal range is 2 to 16.
REQ-004 Parameter SEED, default 16'hACE1, SHALL set the LFSR reset value; it must be non-zero.
REQ-005 Port clk, input, 1 bit, SHALL be the single clock.
REQ-006 Port rst_n, input, 1 bit, SHALL be the reset, which is asynchronous and active-low.
REQ-007 Port cmd_valid, input, 1 bit, SHALL indicate that a command is offered.
REQ-008 Port cmd_press, input, 1 bit, SHALL select the target level: 1 = press (key_out driven to 0), 0 = release (key_out driven to 1).
REQ-009 Port cmd_ready, output, 1 bit, SHALL indicate that the block can accept a command.
REQ-010 Port key_out, output, 1 bit, SHALL be the emulated active-low mechanical key line, including bounce.
REQ-011 Port busy, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-012 Port done, output, 1 bit, SHALL be a one-cycle pulse marking that key_out has been stable at the target for SETTLE_LEN cycles.

Function
REQ-013 The block SHALL be the stimulus-side counterpart of the team's key debounce filter: it turns press and release commands into a bouncing key line.
REQ-014 The FSM SHALL use one-hot states: IDLE=4'b0001, BOUNCE=4'b0010, SETTLE=4'b0100, DONE=4'b1000.
REQ-015 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on a rising clk edge where cmd_valid=1 and cmd_ready=1.
REQ-016 cmd_valid SHALL be ignored outside IDLE; there is no queueing.
REQ-017 On acceptance with target != key_out: state goes to BOUNCE; key_out inverts on that same edge; window_cnt is cleared to 0; glitch_cnt is loaded with max(lfsr[GLITCH_W-1:0], 1).
REQ-018 On acceptance with target == key_out: state goes directly to DONE; key_out does not change.
REQ-019 In BOUNCE, window_cnt SHALL increment by 1 every cycle.
REQ-020 In BOUNCE, glitch_cnt SHALL decrement by 1 every cycle; when it reaches 1, key_out inverts and glitch_cnt reloads from the current LFSR value, with a minimum of 1.
REQ-021 When window_cnt == BOUNCE_LEN-1 in BOUNCE: key_out is forced to the target; settle_cnt is cleared; state goes to SETTLE. This SHALL take priority over a coincident glitch toggle.
REQ-022 In SETTLE, key_out SHALL hold the target; settle_cnt increments; at settle_cnt == SETTLE_LEN-1 the state goes to DONE.
REQ-023 In DONE, done SHALL equal 1 for exactly one cycle, and the state returns to IDLE on the next edge.
REQ-024 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11; it advances every cycle after reset, regardless of state.
REQ-025 Counters SHALL be 20 bits wide; glitch_cnt SHALL be GLITCH_W bits wide; no counter may wrap within a legal parameter range.
REQ-026 key_out SHALL be driven from a flop, never from combinational logic.

Reset
REQ-027 Asserting rst_n low at any time, including mid-BOUNCE, SHALL immediately set: state=IDLE, key_out=1, done=0, busy=0, cmd_ready=1 (derived from state), all counters=0, LFSR=SEED.
REQ-028 After rst_n deasserts, the first command SHALL be acceptable on the first clk edge.

Structure
REQ-029 A shared package SHALL hold the state encodings and the LFSR tap constant; the timing parameters stay as module parameters.
REQ-030 The LFSR SHALL be a sub-module named lfsr16, with ports clk, rst_n, seed and q[15:0].

Verification
REQ-031 The bench SHALL use BOUNCE_LEN=64, SETTLE_LEN=16, GLITCH_W=3 unless a scenario states otherwise.
REQ-032 Press scenario: press command from reset -> key_out toggles at least once in the window, stays at 0 for 16 cycles, done pulses 1 cycle exactly 64+16+1 cycles after acceptance, and the debounce filter reports key_state=0 with one key_flag pulse.
REQ-033 Redundant command: release command while key_out=1 -> no key_out edge, and done is high on the cycle after acceptance.
REQ-034 Busy rejection: cmd_valid held high during BOUNCE with the opposite cmd_press -> cmd_ready=0 and no change to target, window or timing.
REQ-035 Reset mid-operation: rst_n pulsed low 20 cycles into BOUNCE -> key_out=1 asynchronously, busy=0, and a new press runs a full 64+16 cycle sequence.
REQ-036 Glitch bound: over 100 random commands, every interior bounce pulse width lies in 1..7 cycles and no pulse starts after window cycle 63.

Source files
------------

// File: rtl/key_bounce_gen_pkg.sv
// Shared encodings for the key bounce generator: one-hot FSM states and LFSR taps.
package key_bounce_gen_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        BOUNCE = 4'b0010,
        SETTLE = 4'b0100,
        DONE   = 4'b1000
    } state_t;

    // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; reloads its seed while reset is held.
module lfsr16
    import key_bounce_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic fb;

    assign fb = ^(q & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= seed;
        else        q <= {q[14:0], fb};
    end

endmodule

// File: rtl/key_bounce_gen.sv
// Emulates a bouncing active-low mechanical key: press/release commands become
// a random-glitch window followed by a stable settle period and a done pulse.
module key_bounce_gen
    import key_bounce_gen_pkg::*;
#(
    parameter int unsigned BOUNCE_LEN = 250000,
    parameter int unsigned SETTLE_LEN = 50000,
    parameter int unsigned GLITCH_W   = 12,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_press,
    output logic cmd_ready,
    output logic key_out,
    output logic busy,
    output logic done
);

    localparam logic [19:0] BOUNCE_LAST = 20'(BOUNCE_LEN - 1);
    localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_LEN - 1);

    state_t              state, state_nxt;
    logic                target, target_nxt;
    logic                key_nxt;
    logic [19:0]         window_cnt, window_nxt;
    logic [19:0]         settle_cnt, settle_nxt;
    logic [GLITCH_W-1:0] glitch_cnt, glitch_nxt;
    logic [GLITCH_W-1:0] glitch_load;
    logic [15:0]         lfsr_q;
    logic                lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // Only the low GLITCH_W bits set pulse widths; a zero draw becomes 1.
    assign lfsr_unused = ^lfsr_q;
    assign glitch_load = (lfsr_q[GLITCH_W-1:0] == '0) ? GLITCH_W'(1)
                                                      : lfsr_q[GLITCH_W-1:0];

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        key_nxt    = key_out;
        window_nxt = window_cnt;
        settle_nxt = settle_cnt;
        glitch_nxt = glitch_cnt;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    target_nxt = ~cmd_press;
                    if (~cmd_press != key_out) begin
                        state_nxt  = BOUNCE;
                        key_nxt    = ~key_out;
                        window_nxt = '0;
                        glitch_nxt = glitch_load;
                    end else begin
                        state_nxt  = DONE;
                    end
                end
            end
            BOUNCE: begin
                window_nxt = window_cnt + 20'd1;
                // End of window wins over a glitch toggle on the same cycle
                if (window_cnt == BOUNCE_LAST) begin
                    key_nxt    = target;
                    settle_nxt = '0;
                    state_nxt  = SETTLE;
                end else if (glitch_cnt == GLITCH_W'(1)) begin
                    key_nxt    = ~key_out;
                    glitch_nxt = glitch_load;
                end else begin
                    glitch_nxt = glitch_cnt - GLITCH_W'(1);
                end
            end
            SETTLE: begin
                key_nxt    = target;
                settle_nxt = settle_cnt + 20'd1;
                if (settle_cnt == SETTLE_LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= 1'b1;
            key_out    <= 1'b1;
            window_cnt <= '0;
            settle_cnt <= '0;
            glitch_cnt <= '0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            key_out    <= key_nxt;
            window_cnt <= window_nxt;
            settle_cnt <= settle_nxt;
            glitch_cnt <= glitch_nxt;
        end
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed and randomized-command bench for key_bounce_gen with a small debounce filter model.
module tb_key_bounce_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_press = 1'b0;
    logic cmd_ready, key_out, busy, done;

    int n_checks = 0;
    int n_err = 0;

    key_bounce_gen #(
        .BOUNCE_LEN (64),
        .SETTLE_LEN (16),
        .GLITCH_W   (3),
        .SEED       (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_press (cmd_press),
        .cmd_ready (cmd_ready),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Debounce filter model: level must hold 10 cycles before key_state follows
    logic db_prev, db_state;
    int   db_cnt, flag_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev <= 1'b1; db_state <= 1'b1; db_cnt <= 0; flag_cnt <= 0;
        end else if (key_out != db_prev) begin
            db_prev <= key_out; db_cnt <= 0;
        end else if (key_out != db_state) begin
            if (db_cnt == 9) begin
                db_state <= key_out; flag_cnt <= flag_cnt + 1; db_cnt <= 0;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one command, hold cmd_valid (with the opposite press) for `hold` cycles,
    // and measure key_out edges relative to the accepting edge (offset 0).
    task automatic run_cmd(input logic press, input int hold,
                           output int done_off, output int n_edges, output int max_gap,
                           output int late_edges, output int ready_hi);
        logic prev;
        int   last_e;
        done_off = -1; n_edges = 0; max_gap = 0; late_edges = 0; ready_hi = 0; last_e = -1;
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        chk("ready_wait", cmd_ready, 1);
        prev = key_out;
        cmd_valid = 1'b1;
        cmd_press = press;
        for (int off = 0; off < 120; off++) begin
            @(negedge clk);
            if (off < hold && cmd_ready) ready_hi++;
            if (key_out != prev) begin
                n_edges++;
                if (off > 64) late_edges++;
                if (last_e >= 0 && off - last_e > max_gap) max_gap = off - last_e;
                last_e = off;
                prev = key_out;
            end
            if (off == 0) cmd_press = ~press;
            if (off + 1 >= hold) cmd_valid = 1'b0;
            if (done) begin
                done_off = off;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        int   off;
        logic chk_key;
        logic key;
        logic bsy;
        logic rdy;
        logic dn;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int ti, edges_win, low_hold, d_off, ne, mg, late, rh;
        logic prev, exp_key, press;

        // Press from reset: LFSR starts at ACE1, so glitches are 1, 3, 6 cycles wide
        tbl[0]  = '{0,  1, 0, 1, 0, 0};
        tbl[1]  = '{1,  1, 1, 1, 0, 0};
        tbl[2]  = '{3,  1, 1, 1, 0, 0};
        tbl[3]  = '{4,  1, 0, 1, 0, 0};
        tbl[4]  = '{9,  1, 0, 1, 0, 0};
        tbl[5]  = '{10, 1, 1, 1, 0, 0};
        tbl[6]  = '{63, 0, 0, 1, 0, 0};
        tbl[7]  = '{64, 1, 0, 1, 0, 0};
        tbl[8]  = '{79, 1, 0, 1, 0, 0};
        tbl[9]  = '{80, 1, 0, 1, 0, 1};
        tbl[10] = '{81, 1, 0, 0, 1, 0};

        repeat (2) @(negedge clk);
        chk("rst_key", key_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);

        rst_n = 1'b1;
        cmd_valid = 1'b1;
        cmd_press = 1'b1;
        prev = 1'b1;
        ti = 0; edges_win = 0; low_hold = 0;
        for (int off = 0; off <= 81; off++) begin
            @(negedge clk);
            if (off == 0) cmd_valid = 1'b0;
            if (off <= 64 && key_out != prev) edges_win++;
            if (off >= 64 && off <= 80 && key_out == 1'b0) low_hold++;
            prev = key_out;
            if (ti < 11 && tbl[ti].off == off) begin
                if (tbl[ti].chk_key) chk($sformatf("press_key@%0d", off), key_out, tbl[ti].key);
                chk($sformatf("press_busy@%0d", off), busy, tbl[ti].bsy);
                chk($sformatf("press_ready@%0d", off), cmd_ready, tbl[ti].rdy);
                chk($sformatf("press_done@%0d", off), done, tbl[ti].dn);
                ti++;
            end
        end
        chk("press_edges_ge2", int'(edges_win >= 2), 1);
        chk("press_low_hold", low_hold, 17);
        chk("debounce_state", db_state, 0);
        chk("debounce_flags", flag_cnt, 1);

        run_cmd(1'b0, 0, d_off, ne, mg, late, rh);
        chk("release_done_off", d_off, 80);
        chk("release_key", key_out, 1);
        chk("release_late", late, 0);

        run_cmd(1'b0, 0, d_off, ne, mg, late, rh);
        chk("redundant_done_off", d_off, 0);
        chk("redundant_edges", ne, 0);
        @(negedge clk);
        chk("redundant_done_1cyc", done, 0);

        run_cmd(1'b1, 70, d_off, ne, mg, late, rh);
        chk("busy_ready_hi", rh, 0);
        chk("busy_done_off", d_off, 80);
        chk("busy_key", key_out, 0);
        run_cmd(1'b0, 0, d_off, ne, mg, late, rh);
        chk("busy_restore_key", key_out, 1);

        // Reset pulse 20 cycles into the bounce window
        for (int i = 0; i < 200 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_press = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_key", key_out, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(1'b1, 0, d_off, ne, mg, late, rh);
        chk("midrst_done_off", d_off, 80);
        chk("midrst_key_final", key_out, 0);
        chk("midrst_edges", int'(ne >= 2), 1);

        exp_key = key_out;
        for (int n = 0; n < 100; n++) begin
            press = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_cmd(press, 0, d_off, ne, mg, late, rh);
            if (~press == exp_key) begin
                chk($sformatf("rnd%0d_redundant", n), d_off * 1000 + ne, 0);
            end else begin
                chk($sformatf("rnd%0d_done_off", n), d_off, 80);
                chk($sformatf("rnd%0d_pulse_ok", n),
                    int'(mg <= 7 && late == 0 && ne >= 1 && key_out == ~press), 1);
            end
            exp_key = ~press;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
